// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// master: the producer/consumer side; slave: the serializer itself.
interface piso_serializer_if #(
  parameter int WIDTH = 4
);
  logic             bit_en;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_first;
  logic             busy;

  modport master (
    output bit_en,
    output load_valid,
    output load_data,
    input  load_ready,
    input  ser_out,
    input  ser_valid,
    input  ser_first,
    input  busy
  );

  modport slave (
    input  bit_en,
    input  load_valid,
    input  load_data,
    output load_ready,
    output ser_out,
    output ser_valid,
    output ser_first,
    output busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter with a valid/ready load port.
// A word is accepted, then sent one bit per bit_en clock, framed by
// ser_valid/ser_first. A new word can be taken on the last-bit cycle
// so consecutive frames run with no idle bit between them.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic         clk,
  input logic         reset,
  piso_serializer_if.slave bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;     // bits still to be sent, next one at the head
  logic [CW-1:0]    count_q, count_d;     // bits remaining after the one on ser_out
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_first_q, ser_first_d;

  logic             last_bit;
  logic             load_ready;
  logic             xfer;

  // Bit that leaves the word first, depending on transmit order.
  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word with its head bit removed, so the next bit becomes the head.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The last bit of a frame is on the line when count has run out.
  assign last_bit   = (state_q == ST_SHIFT) && (count_q == '0);
  // Ready in IDLE, or when the last bit is about to be retired.
  assign load_ready = (state_q == ST_IDLE) || (last_bit && bus.bit_en);
  assign xfer       = bus.load_valid && load_ready;

  // Next-state logic: load, shift, stretch or return to IDLE.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    count_d     = count_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_first_d = ser_first_q;

    if (xfer) begin
      // Load is the same from IDLE and from the last-bit cycle.
      state_d     = ST_SHIFT;
      ser_out_d   = head_bit(bus.load_data);
      shreg_d     = advance(bus.load_data);
      count_d     = LAST_COUNT;
      ser_valid_d = 1'b1;
      ser_first_d = 1'b1;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (bus.bit_en) begin
            if (count_q != '0) begin
              ser_out_d   = head_bit(shreg_q);
              shreg_d     = advance(shreg_q);
              count_d     = count_q - 1'b1;
              ser_first_d = 1'b0;
            end else begin
              // Frame complete and nothing queued behind it.
              state_d     = ST_IDLE;
              shreg_d     = '0;
              count_d     = '0;
              ser_out_d   = 1'b0;
              ser_valid_d = 1'b0;
              ser_first_d = 1'b0;
            end
          end
          // bit_en low: everything holds, stretching the current bit.
        end
        default: begin
          state_d     = ST_IDLE;
          ser_out_d   = 1'b0;
          ser_valid_d = 1'b0;
          ser_first_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      count_q     <= '0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      count_q     <= count_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_first_q <= ser_first_d;
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_valid  = ser_valid_q;
  assign bus.ser_first  = ser_first_q;
  assign bus.busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance run
// on identical stimulus. Accepted words push their expected bit stream
// into a scoreboard queue; a monitor pops one entry whenever a new bit
// should appear and checks framing, stretching, ready and busy each cycle.
module tb_piso_serializer;

  localparam int W = 4;

  typedef struct packed {
    logic msb_b;
    logic lsb_b;
    logic first;
  } exp_t;

  logic clk;
  logic reset;
  logic bit_en;
  logic load_valid;
  logic [W-1:0] load_data;

  piso_serializer_if #(.WIDTH(W)) bus_m ();
  piso_serializer_if #(.WIDTH(W)) bus_l ();

  assign bus_m.bit_en     = bit_en;
  assign bus_m.load_valid = load_valid;
  assign bus_m.load_data  = load_data;
  assign bus_l.bit_en     = bit_en;
  assign bus_l.load_valid = load_valid;
  assign bus_l.load_data  = load_data;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t         exp_q[$];
  logic [W-1:0] tx_q[$];
  int           en_mode   = 0;    // 0: always on, 1: toggling, 2: random
  int           valid_pct = 100;
  bit           en_phase  = 1'b1;
  bit           holding   = 1'b0;
  bit           from_q    = 1'b0;
  bit           pulse_req = 1'b0;
  logic [W-1:0] pulse_data = '0;

  // Reference model state: bits of the current frame still to be shown
  // (including the one on the line), and what the line should carry.
  int   rem       = 0;
  int   bits_seen = 0;
  exp_t cur       = '0;
  bit   prev_en   = 1'b0;
  bit   prev_xfer = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: new inputs just after each rising edge.
  initial begin : driver
    bit_en     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      case (en_mode)
        0:       bit_en = 1'b1;
        1:       begin bit_en = en_phase; en_phase = ~en_phase; end
        default: bit_en = 1'($urandom_range(0, 1));
      endcase
      if (pulse_req) begin
        load_valid = 1'b1;
        load_data  = pulse_data;
        from_q     = 1'b0;
        pulse_req  = 1'b0;
      end else if (holding) begin
        load_valid = 1'b1;
        load_data  = tx_q[0];
        from_q     = 1'b1;
      end else if (tx_q.size() > 0 && $urandom_range(1, 100) <= valid_pct) begin
        holding    = 1'b1;
        load_valid = 1'b1;
        load_data  = tx_q[0];
        from_q     = 1'b1;
      end else begin
        load_valid = 1'b0;
        load_data  = W'($urandom);
        from_q     = 1'b0;
      end
    end
  end

  // Stimulus side of the scoreboard: on an accepted word, queue its bits.
  initial begin : acceptor
    logic [W-1:0] w;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && load_valid && bus_m.load_ready) begin
        w = load_data;
        for (int i = 0; i < W; i++) begin
          e.msb_b = w[W-1-i];
          e.lsb_b = w[i];
          e.first = (i == 0);
          exp_q.push_back(e);
        end
        $display("load word %b", w);
        if (from_q) begin
          void'(tx_q.pop_front());
          holding = 1'b0;
        end
      end
    end
  end

  // Monitor: advance the model over the edge just passed, then compare.
  initial begin : monitor
    bit new_bit;
    bit exp_ready;
    forever begin
      @(negedge clk);
      if (!reset) begin
        rem       = 0;
        exp_q.delete();
        prev_en   = 1'b0;
        prev_xfer = 1'b0;
        cur       = '0;
      end else begin
        new_bit = 1'b0;
        if (rem == 0) begin
          if (prev_xfer) begin rem = W; new_bit = 1'b1; end
        end else if (prev_en) begin
          if (rem > 1) begin
            rem--;
            new_bit = 1'b1;
          end else if (prev_xfer) begin
            rem = W;
            new_bit = 1'b1;
          end else begin
            rem = 0;
          end
        end
        if (new_bit) begin
          check("sb_underflow", 32'(exp_q.size() > 0), 32'd1);
          cur = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          bits_seen++;
          $display("bit %0d: msb_out=%b lsb_out=%b first=%b", bits_seen,
                   bus_m.ser_out, bus_l.ser_out, bus_m.ser_first);
        end
        if (rem == 0) cur = '0;
        check("ser_valid_msb", 32'(bus_m.ser_valid), 32'(rem > 0));
        check("ser_valid_lsb", 32'(bus_l.ser_valid), 32'(rem > 0));
        check("busy_msb",      32'(bus_m.busy),      32'(rem > 0));
        check("busy_lsb",      32'(bus_l.busy),      32'(rem > 0));
        check("ser_out_msb",   32'(bus_m.ser_out),   32'(cur.msb_b));
        check("ser_out_lsb",   32'(bus_l.ser_out),   32'(cur.lsb_b));
        check("ser_first_msb", 32'(bus_m.ser_first), 32'(cur.first));
        check("ser_first_lsb", 32'(bus_l.ser_first), 32'(cur.first));
        exp_ready = (rem == 0) || (rem == 1 && bit_en);
        check("load_ready_msb", 32'(bus_m.load_ready), 32'(exp_ready));
        check("load_ready_lsb", 32'(bus_l.load_ready), 32'(exp_ready));
        prev_xfer = load_valid && exp_ready;
        prev_en   = bit_en;
      end
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(tx_q.size() == 0 && !holding && !pulse_req && rem == 0 &&
                 exp_q.size() == 0) && n < budget);
    check(name, 32'(n < budget), 32'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_bits(input string name, input int n);
    int target = bits_seen + n;
    int k = 0;
    while (bits_seen < target && k < 60) begin
      @(negedge clk); #1;
      k++;
    end
    check(name, 32'(bits_seen >= target), 32'd1);
  endtask

  initial begin : main
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ser_out",   32'({bus_m.ser_out,   bus_l.ser_out}),   32'd0);
    check("rst_ser_valid", 32'({bus_m.ser_valid, bus_l.ser_valid}), 32'd0);
    check("rst_ser_first", 32'({bus_m.ser_first, bus_l.ser_first}), 32'd0);
    check("rst_busy",      32'({bus_m.busy,      bus_l.busy}),      32'd0);
    check("rst_ready",     32'({bus_m.load_ready, bus_l.load_ready}), 32'd3);
    #1 reset = 1'b1;

    // Single word from IDLE, then the LSB-first pattern 0001.
    tx_q.push_back(4'b1011);
    wait_idle("idle_single", 40);
    tx_q.push_back(4'b0001);
    wait_idle("idle_0001", 40);

    // Back-to-back frames with load_valid held.
    tx_q.push_back(4'b1011);
    tx_q.push_back(4'b0110);
    wait_idle("idle_b2b", 60);

    // bit_en alternating: every bit stretched over two cycles.
    en_mode  = 1;
    en_phase = 1'b1;
    tx_q.push_back(4'b1100);
    wait_idle("idle_toggle", 60);
    en_mode = 0;

    // Mid-frame pulse while not ready must be ignored.
    tx_q.push_back(4'b1011);
    wait_bits("bits_pulse", 1);
    pulse_data = 4'b0101;
    pulse_req  = 1'b1;
    wait_idle("idle_pulse", 40);

    // Reset in the middle of a frame clears outputs without a clock.
    tx_q.push_back(4'b1111);
    wait_bits("bits_reset", 2);
    reset = 1'b0;
    #1;
    check("abort_ser_out",   32'({bus_m.ser_out,   bus_l.ser_out}),   32'd0);
    check("abort_ser_valid", 32'({bus_m.ser_valid, bus_l.ser_valid}), 32'd0);
    check("abort_ser_first", 32'({bus_m.ser_first, bus_l.ser_first}), 32'd0);
    check("abort_busy",      32'({bus_m.busy,      bus_l.busy}),      32'd0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_ready", 32'({bus_m.load_ready, bus_l.load_ready}), 32'd3);

    // Randomized traffic.
    en_mode   = 2;
    valid_pct = 60;
    for (int i = 0; i < 40; i++) tx_q.push_back(W'($urandom));
    wait_idle("idle_random", 3000);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
